mdu_unit: RTL
=============

Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the P5 pipelined MIPS core.
- Sits beside the ALU and consumes the same forwarded operands (in_a = rs, in_b = rt).
- Its mfhi/mflo read value joins the ALU result at the EX-stage result mux before the EX/MEM register.
- Owns the HI/LO architectural registers and generates the D-stage stall for HI/LO hazards.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (and madd family when enabled); minimum 1.
- DIV_CYCLES, 10: busy cycles for div/divu; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  E-stage instruction is a valid MDU op this cycle; qualifies mdu_op.
- mdu_op  input  4  operation code, encodings in the package.
- in_a  input  32  forwarded rs value.
- in_b  input  32  forwarded rt value.
- d_is_md  input  1  D-stage instruction is any MDU op (mult..mflo).
- busy  output  1  multi-cycle operation in flight.
- md_stall  output  1  D-stage stall request.
- hi  output  32  HI register.
- lo  output  32  LO register.
- md_result  output  32  hi when mdu_op==MFHI, lo when mdu_op==MFLO, else 0; combinational.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, counter=0, hi=lo=0, staged hi/lo=0, busy=0. Reset during BUSY aborts the operation; no HI/LO update.
- States:
  - IDLE to BUSY on a rising edge with start=1 and mdu_op in {MULT, MULTU, DIV, DIVU}.
  - BUSY to IDLE when the counter reaches 0.
- Start edge: operands are latched, the 64-bit result is staged, and counter=N-1 (N = MULT_CYCLES or DIV_CYCLES).
- In BUSY, each edge decrements the counter. On the edge where counter==0, hi/lo take the staged values and state returns to IDLE.
- busy==1 for exactly N cycles after the start edge. New hi/lo are visible the cycle busy falls.
- MULT: signed 32x32 to 64; hi=[63:32], lo=[31:0]. MULTU: unsigned.
- DIV: lo=quotient truncated toward zero; hi=remainder, same sign as the dividend.
- DIVU: unsigned quotient and remainder.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (in_b==0, signed or unsigned): full busy period is still spent; hi/lo unchanged at completion.
- MTHI/MTLO with start=1 in IDLE: hi (or lo) <= in_a at that edge, no busy.
- start while busy: ignored, no state change. Upstream guarantees this cannot occur via md_stall.
- md_stall = d_is_md & (busy | (start & mdu_op in {MULT, MULTU, DIV, DIVU})); combinational, no register.
- mfhi/mflo during BUSY returns pre-operation values. md_stall prevents an in-flight op from being read.
- Undefined mdu_op with start=1: no effect.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: MADD, MADDU, MSUB, MSUBU are accepted. {hi,lo} <= {hi,lo} ± product (signed or unsigned per op), using the hi/lo values at the start edge. Takes MULT_CYCLES; the accumulate is written at completion.
- Not defined: these codes are treated as undefined (no effect, no busy).

Decomposition:
- Package mdu_pkg holds:
  - mdu_op encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12.
  - State encoding: IDLE/BUSY.
  - Default cycle counts.
- One natural sub-module, mdu_calc: a purely combinational 64-bit result generator (mult/div/accumulate), selected by mdu_op.
- mdu_unit keeps the FSM, counter, HI/LO and stall logic.

Test Plan:
- MULT, in_a=0xFFFFFFFE (-2), in_b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU, in_a=0xFFFFFFFF, in_b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV, in_a=-7 (0xFFFFFFF9), in_b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> hi/lo unchanged after 10 cycles.
- MTHI 0x12345678, then mfhi next cycle -> md_result=0x12345678, busy never asserted. Then MULT start with d_is_md=1 -> md_stall=1 from the start cycle through the final busy cycle.
- Reset pulled low at cycle 3 of a DIV -> immediately busy=0, hi=lo=0. After release, a new MULT 2*3 gives lo=6.
- With MDU_MADD_EN: hi=0, lo=10, MADD 4*5 -> lo=30, hi=0. Without the macro the same op leaves lo=10.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - mdu_op encodings, FSM state type, default busy-cycle counts.
//   - is_long_op(): true for ops that occupy the unit for several cycles.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
package mdu_pkg;

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMthi  = 4'd5,
    OpMtlo  = 4'd6,
    OpMfhi  = 4'd7,
    OpMflo  = 4'd8,
    OpMadd  = 4'd9,
    OpMaddu = 4'd10,
    OpMsub  = 4'd11,
    OpMsubu = 4'd12
  } mdu_op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } mdu_state_e;

  localparam int unsigned MultCyclesDef = 5;
  localparam int unsigned DivCyclesDef  = 10;

  function automatic logic is_long_op(input logic [3:0] op);
    case (op)
      OpMult, OpMultu, OpDiv, OpDivu: return 1'b1;
`ifdef MDU_MADD_EN
      OpMadd, OpMaddu, OpMsub, OpMsubu: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational 64-bit result generator for the MDU.
// Ports:
//   i_op  - mdu_op code
//   i_a   - rs operand, i_b - rt operand
//   i_hi  - current HI, i_lo - current LO (accumulate base)
//   o_res - {hi, lo} result to stage
//   o_wr  - result should be written to HI/LO at completion (0 on divide by zero)
// Optional feature macro: MDU_MADD_EN (multiply-accumulate/subtract).
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [63:0] o_res,
  output logic        o_wr
);

  logic        w_signed;
  logic [63:0] w_a64;
  logic [63:0] w_b64;
  logic [63:0] w_prod;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_signed = (i_op == OpMult) || (i_op == OpDiv) || (i_op == OpMadd) || (i_op == OpMsub);

  // Low 64 bits of a 64x64 product of extended operands are the exact 32x32 result.
  assign w_a64  = {{32{w_signed & i_a[31]}}, i_a};
  assign w_b64  = {{32{w_signed & i_b[31]}}, i_b};
  assign w_prod = w_a64 * w_b64;

  // Signed divide via magnitudes; 0x80000000 / -1 naturally yields q=0x80000000, r=0.
  assign w_a_neg = w_signed & i_a[31];
  assign w_b_neg = w_signed & i_b[31];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;
  assign w_q_mag = (w_b_mag == '0) ? '0 : w_a_mag / w_b_mag;
  assign w_r_mag = (w_b_mag == '0) ? '0 : w_a_mag % w_b_mag;
  assign w_quot  = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
  assign w_rem   = w_a_neg ? -w_r_mag : w_r_mag;

`ifdef MDU_MADD_EN
  logic [63:0] w_acc;
  assign w_acc = {i_hi, i_lo};
`else
  logic w_unused_acc;
  assign w_unused_acc = ^{i_hi, i_lo};
`endif

  always_comb begin
    o_res = w_prod;
    o_wr  = 1'b0;
    case (i_op)
      OpMult, OpMultu: begin
        o_res = w_prod;
        o_wr  = 1'b1;
      end
      OpDiv, OpDivu: begin
        o_res = {w_rem, w_quot};
        o_wr  = (i_b != '0);
      end
`ifdef MDU_MADD_EN
      OpMadd, OpMaddu: begin
        o_res = w_acc + w_prod;
        o_wr  = 1'b1;
      end
      OpMsub, OpMsubu: begin
        o_res = w_acc - w_prod;
        o_wr  = 1'b1;
      end
`endif
      default: begin
        o_res = w_prod;
        o_wr  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit for the EX stage; owns HI/LO.
// Ports:
//   clk, reset (async, active-low)
//   start     - E-stage MDU op valid; mdu_op - op code; in_a/in_b - rs/rt
//   d_is_md   - D-stage instruction is an MDU op
//   busy      - multi-cycle op in flight; md_stall - D-stage stall request
//   hi, lo    - architectural HI/LO; md_result - mfhi/mflo read value
// Optional feature macro: MDU_MADD_EN (multiply-accumulate ops, via mdu_pkg/mdu_calc).
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDef,
  parameter int unsigned DIV_CYCLES  = DivCyclesDef
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_result
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  mdu_state_e    r_state;
  mdu_state_e    w_state_d;
  logic [CntW-1:0] r_cnt;
  logic [63:0]   r_res;
  logic          r_wr;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;

  logic [63:0]   w_calc_res;
  logic          w_calc_wr;
  logic          w_idle;
  logic          w_long;
  logic          w_go;
  logic          w_done;
  logic [CntW-1:0] w_load;

  mdu_calc u_calc (
    .i_op  (mdu_op),
    .i_a   (in_a),
    .i_b   (in_b),
    .i_hi  (r_hi),
    .i_lo  (r_lo),
    .o_res (w_calc_res),
    .o_wr  (w_calc_wr)
  );

  assign w_idle = (r_state == StIdle);
  assign w_long = is_long_op(mdu_op);
  assign w_go   = start & w_idle & w_long;
  assign w_done = (r_state == StBusy) && (r_cnt == '0);
  assign w_load = ((mdu_op == OpDiv) || (mdu_op == OpDivu)) ? CntW'(DIV_CYCLES - 1)
                                                            : CntW'(MULT_CYCLES - 1);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_go) w_state_d = StBusy;
      StBusy:  if (r_cnt == '0) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_res   <= '0;
      r_wr    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_go) begin
        r_res <= w_calc_res;
        r_wr  <= w_calc_wr;
        r_cnt <= w_load;
      end else if ((r_state == StBusy) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_done) begin
        if (r_wr) begin
          r_hi <= r_res[63:32];
          r_lo <= r_res[31:0];
        end
      end else if (start && w_idle) begin
        if (mdu_op == OpMthi) r_hi <= in_a;
        if (mdu_op == OpMtlo) r_lo <= in_a;
      end
    end
  end

  assign busy     = (r_state == StBusy);
  assign md_stall = d_is_md & (busy | (start & w_long));
  assign hi       = r_hi;
  assign lo       = r_lo;

  always_comb begin
    md_result = '0;
    case (mdu_op)
      OpMfhi:  md_result = r_hi;
      OpMflo:  md_result = r_lo;
      default: md_result = '0;
    endcase
  end

endmodule
